// File: rtl/calc_result_display_if.sv
// Result bus between the calculator core (master) and the display
// consumer (slave): load strobe with its operand, plus the conversion
// status and the BCD result returned by the consumer.
interface calc_result_display_if;
    logic [7:0]  result_in;
    logic        load;
    logic        busy;
    logic        bcd_valid;
    logic [11:0] bcd_out;

    modport master (
        output result_in,
        output load,
        input  busy,
        input  bcd_valid,
        input  bcd_out
    );

    modport slave (
        input  result_in,
        input  load,
        output busy,
        output bcd_valid,
        output bcd_out
    );
endinterface

// File: rtl/calc_result_display.sv
// Result display consumer: captures an 8-bit unsigned result on load,
// converts it to three BCD digits with a bit-serial double-dabble engine
// (one bit per clock), and time-multiplexes the digits onto a single
// 7-segment output with one-hot digit selects.
module calc_result_display #(
    parameter int REFRESH_DIV = 1024,  // cycles per digit, >= 2
    parameter bit BLANK_LZ    = 1'b1   // 1: blank leading zeros
) (
    input  logic                clk,
    input  logic                rst_n,
    calc_result_display_if.slave bus,
    output logic [6:0]          seg,
    output logic [2:0]          dig_sel
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    // Conversion state
    logic [0:0]  state_reg;
    logic [7:0]  shift_reg;
    logic [11:0] scratch_reg;
    logic [2:0]  bit_cnt_reg;
    logic [11:0] bcd_out_reg;
    logic        bcd_valid_reg;

    // Display refresh state
    logic [CNT_W-1:0] refresh_cnt_reg;
    logic [1:0]       digit_idx_reg;

    // Double-dabble datapath
    logic [11:0] scratch_adj;
    logic [11:0] scratch_next;

    // Display datapath
    logic [3:0] digit_val;
    logic       digit_blank;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Add-3 correction: each BCD nibble >= 5 is biased before the shift so
    // that doubling carries correctly into the next decimal digit.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign scratch_adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                                          ? scratch_reg[gi*4 +: 4] + 4'd3
                                          : scratch_reg[gi*4 +: 4];
        end
    endgenerate

    // Shift the corrected scratch left, pulling in the next operand MSB.
    // The bit shifted out of the hundreds nibble is always zero for 0..255.
    assign scratch_next = (scratch_adj << 1) | {11'd0, shift_reg[7]};

    // Conversion FSM: capture on load in IDLE, eight shift steps in CONV,
    // publish the result on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            shift_reg     <= 8'd0;
            scratch_reg   <= 12'd0;
            bit_cnt_reg   <= 3'd0;
            bcd_out_reg   <= 12'h000;
            bcd_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.load) begin
                        shift_reg   <= bus.result_in;
                        scratch_reg <= 12'd0;
                        bit_cnt_reg <= 3'd0;
                        state_reg   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    scratch_reg <= scratch_next;
                    shift_reg   <= shift_reg << 1;
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        bcd_out_reg   <= scratch_next;
                        bcd_valid_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Free-running refresh divider; each wrap advances the shown digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt_reg <= '0;
            digit_idx_reg   <= 2'd0;
        end else begin
            if (refresh_cnt_reg == CNT_LAST) begin
                refresh_cnt_reg <= '0;
                digit_idx_reg   <= (digit_idx_reg == 2'd2) ? 2'd0 : digit_idx_reg + 2'd1;
            end else begin
                refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
            end
        end
    end

    // One-hot digit enable decoded from the digit index.
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sel
            assign dig_sel[gi] = (digit_idx_reg == 2'(gi));
        end
    endgenerate

    // Pick the selected digit, apply leading-zero blanking, encode segments.
    always_comb begin
        digit_val   = bcd_out_reg[3:0];
        digit_blank = 1'b0;
        case (digit_idx_reg)
            2'd1: begin
                digit_val   = bcd_out_reg[7:4];
                digit_blank = BLANK_LZ && (bcd_out_reg[11:4] == 8'h00);
            end
            2'd2: begin
                digit_val   = bcd_out_reg[11:8];
                digit_blank = BLANK_LZ && (bcd_out_reg[11:8] == 4'h0);
            end
            default: begin
                digit_val   = bcd_out_reg[3:0];
                digit_blank = 1'b0;
            end
        endcase
        seg = digit_blank ? 7'h00 : seg_code(digit_val);
    end

    assign bus.busy      = (state_reg == ST_CONV);
    assign bus.bcd_valid = bcd_valid_reg;
    assign bus.bcd_out   = bcd_out_reg;

endmodule

// File: tb/tb_calc_result_display.sv
// Bench for calc_result_display: table of values with expected BCD and
// per-digit segments, a completion scoreboard, and hand sequences for
// ignored loads, refresh timing, async reset and an exhaustive sweep.
module tb_calc_result_display;

    localparam int RDIV = 4;

    typedef struct {
        logic [7:0]  val;
        logic [11:0] bcd;
        logic [6:0]  seg_h;
        logic [6:0]  seg_t;
        logic [6:0]  seg_o;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg;
    logic [2:0] dig_sel;

    calc_result_display_if bus ();

    calc_result_display #(
        .REFRESH_DIV (RDIV),
        .BLANK_LZ    (1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .seg     (seg),
        .dig_sel (dig_sel)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [11:0] sb_q[$];
    logic        busy_prev = 1'b0;
    vec_t        vecs[6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Raise load now (away from the edge); the next posedge is the load edge.
    task automatic issue(input logic [7:0] v, input bit expect_accept);
        bus.result_in = v;
        bus.load      = 1'b1;
        if (expect_accept) sb_q.push_back(ref_bcd(int'(v)));
        @(posedge clk);
        #1;
        bus.load = 1'b0;
    endtask

    // Count busy-high cycles after the load edge; bounded, expect 8.
    task automatic wait_done(input string name);
        int n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
        end
        check(name, n, 8);
    endtask

    // Observe one full refresh period and compare each digit's segments.
    task automatic check_display(input string name, input vec_t v);
        logic [7:0] got_h = 8'hFF;
        logic [7:0] got_t = 8'hFF;
        logic [7:0] got_o = 8'hFF;
        for (int k = 0; k < 3 * RDIV; k++) begin
            if (k != 0) @(negedge clk);
            case (dig_sel)
                3'b001:  got_o = {1'b0, seg};
                3'b010:  got_t = {1'b0, seg};
                3'b100:  got_h = {1'b0, seg};
                default: check({name, "_onehot"}, dig_sel, 3'b001);
            endcase
        end
        check({name, "_seg_h"}, got_h, {1'b0, v.seg_h});
        check({name, "_seg_t"}, got_t, {1'b0, v.seg_t});
        check({name, "_seg_o"}, got_o, {1'b0, v.seg_o});
    endtask

    // Scoreboard monitor: each busy fall pops one expected result.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_prev = 1'b0;
        end else begin
            if (busy_prev && !bus.busy) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_done", 1, 0);
                end else begin
                    logic [11:0] e;
                    e = sb_q.pop_front();
                    check("sb_bcd", bus.bcd_out, e);
                    check("sb_valid", bus.bcd_valid, 1);
                    $display("txn done: bcd_out=%03h expected=%03h", bus.bcd_out, e);
                end
            end
            busy_prev = bus.busy;
        end
    end

    initial begin
        logic [2:0] prev_sel;
        int         run;
        bit         seen_change;

        vecs[0] = '{8'd0,   12'h000, 7'h00, 7'h00, 7'h3F};
        vecs[1] = '{8'd9,   12'h009, 7'h00, 7'h00, 7'h6F};
        vecs[2] = '{8'd100, 12'h100, 7'h06, 7'h3F, 7'h3F};
        vecs[3] = '{8'd199, 12'h199, 7'h06, 7'h6F, 7'h6F};
        vecs[4] = '{8'd255, 12'h255, 7'h5B, 7'h6D, 7'h6D};
        vecs[5] = '{8'd123, 12'h123, 7'h06, 7'h5B, 7'h4F};

        rst_n         = 1'b0;
        bus.load      = 1'b0;
        bus.result_in = 8'd0;

        // Reset state
        #2;
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.bcd_valid, 0);
        check("rst_bcd", bus.bcd_out, 12'h000);
        check("rst_dig_sel", dig_sel, 3'b001);
        check("rst_seg", seg, 7'h3F);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven conversions and display contents
        for (int i = 0; i < 6; i++) begin
            $display("txn load %0d", vecs[i].val);
            issue(vecs[i].val, 1'b1);
            wait_done("busy_cycles");
            check("tbl_bcd", bus.bcd_out, vecs[i].bcd);
            check_display("tbl", vecs[i]);
        end

        // Refresh timing with 123 showing: in-order rotation, each held RDIV
        @(negedge clk);
        prev_sel    = dig_sel;
        run         = 1;
        seen_change = 1'b0;
        for (int k = 0; k < 6 * RDIV; k++) begin
            @(negedge clk);
            if (dig_sel == prev_sel) begin
                run++;
            end else begin
                if (seen_change) check("dig_hold", run, RDIV);
                check("dig_order", dig_sel, {prev_sel[1:0], prev_sel[2]});
                seen_change = 1'b1;
                run         = 1;
                prev_sel    = dig_sel;
            end
        end

        // Loads while busy are ignored, including at the completing edge
        $display("txn load 42 with ignored 77 at E3 and E8");
        issue(8'd42, 1'b1);                       // E0
        repeat (2) @(posedge clk);                // E2
        #1;
        bus.result_in = 8'd77;
        bus.load      = 1'b1;
        @(posedge clk);                           // E3
        #1;
        bus.load = 1'b0;
        check("ign_busy_e3", bus.busy, 1);
        repeat (4) @(posedge clk);                // E7
        #1;
        bus.load = 1'b1;
        @(posedge clk);                           // E8
        #1;
        bus.load = 1'b0;
        check("ign_busy_e8", bus.busy, 0);
        check("ign_bcd", bus.bcd_out, 12'h042);
        issue(8'd77, 1'b1);                       // E9: first edge after busy falls
        wait_done("busy_cycles_77");
        check("reload_bcd", bus.bcd_out, 12'h077);

        // Async reset mid-conversion
        $display("txn load 200 aborted by reset");
        issue(8'd200, 1'b0);                      // E0
        repeat (5) @(posedge clk);                // E5
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_valid", bus.bcd_valid, 0);
        check("abort_bcd", bus.bcd_out, 12'h000);
        check("abort_dig_sel", dig_sel, 3'b001);
        check("abort_seg", seg, 7'h3F);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("txn load 200 after reset");
        issue(8'd200, 1'b1);
        wait_done("busy_cycles_200");
        check("post_rst_bcd", bus.bcd_out, 12'h200);

        // Exhaustive back-to-back sweep
        for (int v = 0; v < 256; v++) begin
            issue(8'(v), 1'b1);
            wait_done("sweep_busy");
        end

        @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/calc_result_display.md
Name: calc_result_display

Overview:
- Consumer end of the calculator's 8-bit result bus.
- On a load strobe it captures an unsigned 8-bit result and converts it to three BCD digits with a sequential shift-and-add-3 (double-dabble) engine, one bit per cycle.
- It then time-multiplexes the digits onto a single 7-segment output with digit-select lines, for driving the board LEDs/display.

Parameters:
- REFRESH_DIV, 1024: clk cycles each digit is shown before the mux advances; minimum 2.
- BLANK_LZ, 1: 1 = blank leading zeros (hundreds, then tens); 0 = always show all three digits.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- result_in  input  8  unsigned value to display; sampled only on an accepted load
- load  input  1  single-cycle request to convert result_in
- busy  output  1  high while a conversion is in progress
- bcd_valid  output  1  high once any conversion has completed since reset
- bcd_out  output  12  {hundreds, tens, ones} BCD of the last completed conversion
- seg  output  7  active-high segments {g,f,e,d,c,b,a} of the currently selected digit
- dig_sel  output  3  one-hot active-high digit enable: 001 = ones, 010 = tens, 100 = hundreds

Behaviour:
- Reset (async, rst_n low):
  - FSM = IDLE; busy = 0; bcd_valid = 0; bcd_out = 12'h000.
  - Scratch registers cleared; refresh counter = 0; digit index = 0.
  - Outputs therefore show dig_sel = 001 and seg = 7'h3F.
- FSM states: IDLE, CONV.
- IDLE:
  - load = 1 at edge E0 captures result_in into a shift register, clears the 12-bit BCD scratch, sets bit counter = 0 and moves to CONV.
  - busy = 1 from E0.
- CONV, on each edge E1..E8:
  - Every scratch nibble >= 5 first gets +3.
  - Then {scratch, shift} shifts left by 1, shifting the captured MSB into scratch[0].
  - Counter increments.
- Completion at E8:
  - bcd_out <= final scratch; bcd_valid <= 1; busy <= 0; FSM -> IDLE.
  - Latency: bcd_out is updated 8 cycles after the load edge.
- load while busy = 1 is ignored, including at E8, because busy is still 1 at that edge. A new load is accepted from the first edge after busy falls.
- bcd_out changes only at completion; the display never shows partial scratch values.
- Range: 0..255 only, so the hundreds digit is never > 2.
- Refresh:
  - Free-running counter 0..REFRESH_DIV-1.
  - On wrap, digit index advances 0 -> 1 -> 2 -> 0.
  - The counter runs regardless of FSM state.
- dig_sel is decoded from the index. seg is combinational from the index and bcd_out.
- Segment codes: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F.
- Blanking (BLANK_LZ = 1):
  - Hundreds is blanked (seg = 0) when it is 0.
  - Tens is blanked when both hundreds and tens are 0.
  - Ones is never blanked.
  - dig_sel still rotates while a digit is blanked.
- Reset asserted mid-conversion aborts it immediately: all state returns to reset values and the previous bcd_out is lost (reads 000).

Test Plan:
- Reset, then load with result_in = 8'd255 -> busy high for exactly 8 cycles; bcd_out = 12'h255 and bcd_valid = 1 after E8; busy low.
- Loads of 0, 9, 100, 199 -> bcd_out = 000, 009, 100, 199. With BLANK_LZ = 1, value 9 shows hundreds and tens as seg = 0 and ones as 6F; value 100 shows 06, 3F, 3F.
- Load 42, then load 77 at E3 and again at E8 -> both ignored; bcd_out = 042. Load 77 one cycle after busy falls -> bcd_out = 077 eight cycles later.
- REFRESH_DIV = 4, value 123 -> dig_sel sequence 001, 010, 100 repeating, each held 4 cycles; seg = 4F, 5B, 06 respectively.
- Load 200, assert rst_n low at E5 -> busy = 0, bcd_valid = 0, bcd_out = 000, dig_sel = 001 and seg = 3F immediately (async). After release, load 200 -> 12'h200.
- Exhaustive sweep 0..255, back-to-back loads each accepted right after busy falls -> bcd_out matches the reference decimal digits for every value.
